// File: rtl/bitfifo16_ctrl_if.sv
// bitfifo16_ctrl_if
//   Bundles the producer, consumer and RAM-side signals of the 16x1 bit FIFO
//   controller.
//
//   Handshake rules (both directions): a bit moves on a rising edge where
//   valid and ready are both high. The sender keeps valid and data stable
//   until that transfer happens. in_ready never depends on in_valid, and
//   in_ready has no path from out_ready.
//
//   Signals
//     flush               : synchronous clear of FIFO contents
//     in_bit/in_valid     : producer data and its valid flag
//     in_ready            : write slot open and RAM not full
//     out_bit/out_valid   : registered head-of-FIFO bit and its valid flag
//     out_ready           : consumer accepts out_bit
//     ram_a/ram_d/ram_we  : RAM address, write data, write enable
//     ram_q               : RAM combinational read data
//     count               : bits held in RAM (0..16), output register excluded
//     phase               : debug view of the slot state (0 write, 1 read)
//
//   Modports: slave is the controller, master is its environment
//   (producer, consumer and RAM together).
interface bitfifo16_ctrl_if;
   logic       flush;
   logic       in_bit;
   logic       in_valid;
   logic       in_ready;
   logic       out_bit;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] ram_a;
   logic       ram_d;
   logic       ram_we;
   logic       ram_q;
   logic [4:0] count;
   logic       phase;

   modport slave (
      input  flush, in_bit, in_valid, out_ready, ram_q,
      output in_ready, out_bit, out_valid, ram_a, ram_d, ram_we, count, phase
   );

   modport master (
      output flush, in_bit, in_valid, out_ready, ram_q,
      input  in_ready, out_bit, out_valid, ram_a, ram_d, ram_we, count, phase
   );
endinterface

// File: rtl/bitfifo16_ctrl.sv
// bitfifo16_ctrl
//   Controller for a 16-deep, 1-bit FIFO whose storage is an external 16x1
//   RAM with one address port, clocked write and combinational read. Cycles
//   alternate between a write slot and a read slot, so the single RAM port is
//   never shared within a cycle. The read slot moves the RAM head into a
//   registered output stage with a valid/ready handshake.
//
//   Ports
//     wclk : clock, all state updates on the rising edge
//     rst  : synchronous active-high reset
//     bus  : bitfifo16_ctrl_if.slave (producer, consumer and RAM signals)
module bitfifo16_ctrl (
   input logic             wclk,
   input logic             rst,
   bitfifo16_ctrl_if.slave bus
);

   typedef enum logic {
      PH_WR = 1'b0,
      PH_RD = 1'b1
   } phase_e;

   phase_e     phase_q, phase_d;
   logic [3:0] wptr_q, wptr_d;
   logic [3:0] rptr_q, rptr_d;
   logic [4:0] count_q, count_d;
   logic       out_bit_q, out_bit_d;
   logic       out_valid_q, out_valid_d;

   logic       wr_slot;
   logic       in_ready;
   logic       write;
   logic       load;
   logic       xfer;

   always_comb begin
      wr_slot  = (phase_q == PH_WR);
      in_ready = !rst && !bus.flush && wr_slot && (count_q != 5'd16);
      write    = bus.in_valid && in_ready;
      // Refill the output register when it is empty or emptying this cycle.
      load     = !rst && !bus.flush && !wr_slot && (count_q != 5'd0) &&
                 (!out_valid_q || bus.out_ready);
      xfer     = out_valid_q && bus.out_ready;

      phase_d     = wr_slot ? PH_RD : PH_WR;
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      count_d     = count_q;
      out_bit_d   = out_bit_q;
      out_valid_d = out_valid_q;

      if (bus.flush) begin
         wptr_d      = 4'd0;
         rptr_d      = 4'd0;
         count_d     = 5'd0;
         out_valid_d = 1'b0;
      end else begin
         // write and load sit in different slots, so count moves one way only.
         if (write) begin
            wptr_d  = wptr_q + 4'd1;
            count_d = count_q + 5'd1;
         end
         if (load) begin
            out_bit_d   = bus.ram_q;
            out_valid_d = 1'b1;
            rptr_d      = rptr_q + 4'd1;
            count_d     = count_q - 5'd1;
         end else if (xfer) begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge wclk) begin
      if (rst) begin
         phase_q     <= PH_WR;
         wptr_q      <= 4'd0;
         rptr_q      <= 4'd0;
         count_q     <= 5'd0;
         out_bit_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         phase_q     <= phase_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         count_q     <= count_d;
         out_bit_q   <= out_bit_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.ram_we    = write;
   assign bus.ram_d     = bus.in_bit;
   assign bus.ram_a     = rst ? 4'd0 : (wr_slot ? wptr_q : rptr_q);
   assign bus.out_bit   = out_bit_q;
   assign bus.out_valid = out_valid_q;
   assign bus.count     = count_q;
   assign bus.phase     = phase_q;

endmodule

// File: tb/tb_bitfifo16_ctrl.sv
// tb_bitfifo16_ctrl
//   Directed bench for bitfifo16_ctrl with a behavioural 16x1 RAM. Inputs are
//   driven 1 ns after the rising edge, directed checks run 2 ns after it, and
//   a monitor samples the handshakes on the falling edge to feed and drain an
//   expected-bit queue.
module tb_bitfifo16_ctrl;

   logic wclk;
   logic rst;
   bitfifo16_ctrl_if bus ();

   bitfifo16_ctrl dut (
      .wclk (wclk),
      .rst  (rst),
      .bus  (bus)
   );

   // clock / reset
   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   // behavioural RAM: clocked write, combinational read
   logic mem [16];
   always @(posedge wclk) if (bus.ram_we) mem[bus.ram_a] <= bus.ram_d;
   assign bus.ram_q = mem[bus.ram_a];

   // scoreboard state
   logic       exp_q[$];
   int         n_pass  = 0;
   int         n_total = 0;
   logic       ph_m     = 1'b0;
   logic [3:0] wp_m     = 4'd0;
   logic [3:0] rp_m     = 4'd0;
   logic [4:0] prev_cnt = 5'd0;
   logic       stall_prev = 1'b0;
   logic       bit_prev   = 1'b0;
   logic       cnt_chk    = 1'b0;
   int         n_acc      = 0;

   task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // monitor: expected queue, pointer sequence, output stability
   always @(negedge wclk) begin
      if (rst) begin
         ph_m = 1'b0; wp_m = 4'd0; rp_m = 4'd0; prev_cnt = 5'd0;
         stall_prev = 1'b0;
         exp_q.delete();
      end else begin
         check("phase", {4'd0, bus.phase}, {4'd0, ph_m});
         if (!bus.flush) begin
            if (ph_m == 1'b0) check("ram_a_wr", {1'b0, bus.ram_a}, {1'b0, wp_m});
            else              check("ram_a_rd", {1'b0, bus.ram_a}, {1'b0, rp_m});
         end
         // a RAM bit left for the output register during the last read slot
         if (ph_m == 1'b0 && bus.count < prev_cnt) rp_m = rp_m + 4'd1;
         if (ph_m == 1'b1) prev_cnt = bus.count;
         if (stall_prev) begin
            check("hold_bit", {4'd0, bus.out_bit}, {4'd0, bit_prev});
            check("hold_valid", {4'd0, bus.out_valid}, 5'd1);
         end
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(bus.in_bit);
            wp_m = wp_m + 4'd1;
            n_acc++;
         end
         if (bus.out_valid && bus.out_ready) begin
            check("pop_nonempty", {4'd0, exp_q.size() != 0}, 5'd1);
            if (exp_q.size() != 0) check("out_bit", {4'd0, bus.out_bit}, {4'd0, exp_q.pop_front()});
         end
         if (cnt_chk) check("count_le1", {4'd0, bus.count <= 5'd1}, 5'd1);
         stall_prev = bus.out_valid && !bus.out_ready;
         bit_prev   = bus.out_bit;
         if (bus.flush) begin
            wp_m = 4'd0; rp_m = 4'd0; prev_cnt = 5'd0;
            stall_prev = 1'b0;
            exp_q.delete();
         end
         ph_m = ~ph_m;
      end
   end

   // driver tasks
   task automatic cyc();
      @(posedge wclk);
      #1;
   endtask

   task automatic push(input logic b);
      int n;
      bus.in_valid = 1'b1;
      bus.in_bit   = b;
      #1;
      n = 0;
      while (!bus.in_ready && n < 64) begin
         @(posedge wclk);
         #2;
         n++;
      end
      check("push_wait", {4'd0, n < 64}, 5'd1);
      cyc();
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      n = 0;
      while ((exp_q.size() != 0 || bus.out_valid) && n < 200) begin
         cyc();
         #1;
         n++;
      end
      check("drained", {4'd0, n < 200}, 5'd1);
      check("drain_count", bus.count, 5'd0);
      bus.out_ready = 1'b0;
   endtask

   logic pat [17] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                      1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

   initial begin
      rst = 1'b1;
      bus.flush = 1'b0; bus.in_valid = 1'b1; bus.in_bit = 1'b1; bus.out_ready = 1'b0;

      // reset held 3 cycles with in_valid high
      for (int i = 0; i < 3; i++) begin
         cyc();
         #1;
         check("rst_ram_we", {4'd0, bus.ram_we}, 5'd0);
         check("rst_in_ready", {4'd0, bus.in_ready}, 5'd0);
         check("rst_count", bus.count, 5'd0);
         check("rst_out_valid", {4'd0, bus.out_valid}, 5'd0);
         check("rst_ram_a", {1'b0, bus.ram_a}, 5'd0);
      end

      // release: first cycle is the write slot; write a single 1
      rst = 1'b0;
      bus.in_valid = 1'b1; bus.in_bit = 1'b1; bus.out_ready = 1'b0;
      #1;
      check("rel_phase", {4'd0, bus.phase}, 5'd0);
      check("rel_in_ready", {4'd0, bus.in_ready}, 5'd1);
      check("sb_ram_we", {4'd0, bus.ram_we}, 5'd1);
      check("sb_ram_a", {1'b0, bus.ram_a}, 5'd0);
      cyc();
      bus.in_valid = 1'b0;
      #1;
      check("sb_count1", bus.count, 5'd1);
      cyc();
      #1;
      check("sb_out_valid", {4'd0, bus.out_valid}, 5'd1);
      check("sb_out_bit", {4'd0, bus.out_bit}, 5'd1);
      check("sb_count0", bus.count, 5'd0);
      drain();

      // fill: 1 bit in the output register plus 16 in RAM
      bus.out_ready = 1'b0;
      for (int i = 0; i < 17; i++) push(pat[i]);
      #1;
      check("fill_count", bus.count, 5'd16);
      bus.in_valid = 1'b1; bus.in_bit = 1'b0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         #1;
         check("full_in_ready", {4'd0, bus.in_ready}, 5'd0);
         check("full_ram_we", {4'd0, bus.ram_we}, 5'd0);
      end
      drain();

      // wrap-around: continuous push/pop of random bits
      bus.out_ready = 1'b1;
      cnt_chk = 1'b1;
      n_acc = 0;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 80; i++) begin
         bus.in_bit = 1'($urandom_range(0, 1));
         cyc();
      end
      bus.in_valid = 1'b0;
      #1;
      check("wrap_accepts", {4'd0, n_acc == 40}, 5'd1);
      drain();
      cnt_chk = 1'b0;

      // backpressure: random out_ready with data queued
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) push(1'($urandom_range(0, 1)));
      for (int i = 0; i < 60; i++) begin
         bus.in_valid  = 1'($urandom_range(0, 1));
         bus.in_bit    = 1'($urandom_range(0, 1));
         bus.out_ready = 1'($urandom_range(0, 1));
         cyc();
      end
      drain();

      // flush at count 7 with the output register full
      bus.out_ready = 1'b0;
      for (int i = 0; i < 8; i++) push(1'($urandom_range(0, 1)));
      cyc();
      bus.flush = 1'b1; bus.in_valid = 1'b1; bus.in_bit = 1'b0;
      #1;
      check("fl_phase", {4'd0, bus.phase}, 5'd0);
      check("fl_count7", bus.count, 5'd7);
      check("fl_out_valid_pre", {4'd0, bus.out_valid}, 5'd1);
      check("fl_ram_we", {4'd0, bus.ram_we}, 5'd0);
      check("fl_in_ready", {4'd0, bus.in_ready}, 5'd0);
      cyc();
      bus.flush = 1'b0; bus.in_valid = 1'b0;
      #1;
      check("fl_count0", bus.count, 5'd0);
      check("fl_out_valid", {4'd0, bus.out_valid}, 5'd0);
      check("fl_rptr", {1'b0, bus.ram_a}, 5'd0);
      cyc();
      #1;
      check("fl_wptr", {1'b0, bus.ram_a}, 5'd0);
      push(1'b1);
      push(1'b0);
      #1;
      check("fl_first_valid", {4'd0, bus.out_valid}, 5'd1);
      check("fl_first_bit", {4'd0, bus.out_bit}, 5'd1);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/bitfifo16_ctrl.md
# bitfifo16_ctrl

Controller for a 16-deep, 1-bit FIFO whose storage is an external 16x1 RAM. The RAM has one address port, a posedge-clocked write and a combinational read. This block sits directly upstream of that RAM and drives its address, data and write enable. It also closes the read path: it samples the RAM's combinational output into a registered output stage with a valid/ready handshake. The FIFO carries serial bit streams between producer and consumer logic.

## Interface
Parameters: none. Depth is fixed at 16 and width at 1.

Ports:
- `wclk`  in  1  single clock; all state and the RAM write update on the rising edge
- `rst`  in  1  reset, synchronous and active-high
- `flush`  in  1  synchronous clear of FIFO contents; active-high
- `in_bit`  in  1  producer data
- `in_valid`  in  1  producer has a bit
- `in_ready`  out  1  write slot open and FIFO not full
- `out_bit`  out  1  registered head-of-FIFO bit
- `out_valid`  out  1  `out_bit` holds valid data
- `out_ready`  in  1  consumer accepts `out_bit`
- `ram_a`  out  4  RAM address
- `ram_d`  out  1  RAM write data
- `ram_we`  out  1  RAM write enable
- `ram_q`  in  1  RAM combinational read data
- `count`  out  5  bits held in RAM, 0..16; excludes the output register

## Operation
- **Phase register.** 1-bit `phase` toggles every cycle; it is 0 in the first cycle after `rst` deasserts.
  - phase 0 is the write slot.
  - phase 1 is the read slot.
- **Write slot (phase 0).**
  - `ram_a` = `wptr`.
  - `in_ready` = !rst & !flush & (count != 16).
  - `ram_we` = in_valid & in_ready.
  - `ram_d` = `in_bit`.
  - On accept: `wptr` increments (15 wraps to 0) and `count` increments.
- **Read slot (phase 1).**
  - `ram_a` = `rptr`.
  - `in_ready` = 0 and `ram_we` = 0.
  - load = (count != 0) & (!out_valid | out_ready).
  - On load: `out_bit` <= `ram_q`, `out_valid` <= 1, `rptr` increments (wraps), `count` decrements.
- **Output handshake.** A transfer occurs when out_valid & out_ready.
  - A transfer without a load clears `out_valid`; this can happen in either phase.
  - A transfer together with a load keeps `out_valid` = 1 and presents the new bit.
  - `out_bit` and `out_valid` are stable while out_valid & !out_ready.
- **count.** Never increments and decrements in the same cycle, because the slots are exclusive. Full = 16, empty = 0.
- **Full condition.** Full holds only in RAM. The total FIFO occupancy is count + out_valid, at most 17.
- **flush.** Sampled every cycle.
  - Same cycle: forces `ram_we` = 0 and `in_ready` = 0.
  - Next edge: `wptr` = `rptr` = 0, `count` = 0, `out_valid` = 0.
  - `phase` keeps toggling.
  - Any write or load pending in that cycle is discarded.
- **Reset values (`rst` high at an edge).**
  - `phase` = 0, `wptr` = `rptr` = 0, `count` = 0.
  - `out_valid` = 0, `out_bit` = 0.
  - Combinational outputs while `rst` is high: `in_ready` = 0, `ram_we` = 0, `ram_a` = 0.
- **Reset mid-operation.** Contents are discarded. RAM cells are not cleared; stale data is unreachable because the pointers restart equal.

## Timing
- Write throughput: at most 1 bit per 2 cycles. Read throughput is the same.
- Latency into an empty FIFO:
  - bit accepted at edge N (phase 0);
  - loaded at edge N+1 (phase 1);
  - `out_valid` = 1 from cycle N+1.
- `ram_q` must settle within the phase-1 cycle; it is sampled at the rising edge ending that cycle.
- A write and a read never target the RAM in the same cycle, so no address conflict can occur.
- In wrap-around, `wptr` = `rptr` with `count` = 16 means full; with `count` = 0 it means empty.
- Combinational paths:
  - `in_ready` depends on `phase`, `count`, `rst`, `flush`; it has no path from `out_ready`.
  - `out_valid` and `out_bit` are pure registers.

## Test plan
- **Reset.** Hold `rst` for 3 cycles with `in_valid` = 1.
  - Required: `ram_we` = 0, `in_ready` = 0, `count` = 0, `out_valid` = 0 throughout.
  - After release, first cycle has phase 0 and `in_ready` = 1.
- **Single bit.** Write 1 at the first phase-0 edge with `out_ready` = 0.
  - Required: `ram_a` = 0, `ram_we` = 1 during the write cycle.
  - Next cycle `count` = 1.
  - After the following edge: `out_valid` = 1, `out_bit` = 1, `count` = 0.
- **Fill.** Hold `out_ready` = 0 and stream the pattern 1,0,1,1,0,0,1,0,1,1,1,0,0,0,1,0,1.
  - First bit goes to the output register, next 16 fill the RAM: `count` = 16, `in_ready` stays 0 in phase 0.
  - Then raise `out_ready`: all 17 bits exit in order, one per 2 cycles.
- **Wrap-around.** Push and pop 40 random bits with `out_ready` = 1 throughout.
  - Required: output sequence equals input.
  - `ram_a` cycles 0..15 then 0 again for both pointers.
  - `count` never exceeds 1.
- **Backpressure.** With `out_valid` = 1, toggle `out_ready` randomly.
  - Required: `out_bit` never changes while `out_ready` = 0.
  - No bit is lost or duplicated.
- **Flush.** At `count` = 7 with `out_valid` = 1, assert `flush` for one cycle in phase 0 while `in_valid` = 1.
  - Required: `ram_we` = 0 that cycle.
  - Next cycle: `count` = 0, `out_valid` = 0, pointers = 0.
  - A new bit written afterwards emerges first.
